// File: rtl/delay_rx_buffer.sv
// -----------------------------------------------------------------------------
// delay_rx_buffer
//
// Receive end of a fixed-latency pipeline. Words leaving a LATENCY-cycle delay
// line are written into a DEPTH-entry FIFO and presented on a valid/ready
// output with first-word fall-through. Upstream issues are gated by a credit
// pool of DEPTH slots. Each in-flight word and each stored word holds one
// credit, so every word already launched is guaranteed a free slot even while
// the consumer stalls.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   issue      upstream launches one word into the pipeline
//   issue_ok   upstream may assert issue this cycle (decoded from registers)
//   in_valid   pipeline output word present
//   in_data    pipeline output word
//   out_valid  out_data holds the FIFO head
//   out_ready  consumer accepts the head
//   out_data   FIFO head, 0 when empty
//   count      words currently stored
//   err        sticky protocol-violation flag, cleared only by rst
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module delay_rx_buffer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    output logic                       issue_ok,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    // Parameter sanity: a zero-latency path or an empty FIFO makes no sense.
    if (LATENCY < 1 || DEPTH < 1) begin : g_param_check
        $error("delay_rx_buffer: LATENCY and DEPTH must both be >= 1");
    end

    // Pointer increment with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] res;
        if (ptr == PTR_LAST) begin
            res = {PW{1'b0}};
        end else begin
            res = ptr + {{(PW-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [CW-1:0]    inflight_r;
    logic [CW-1:0]    count_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic             err_r;
    logic             issue_ok_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;

    logic             acc_issue_s;
    logic             push_s;
    logic             pop_s;
    logic [CW-1:0]    inflight_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic             err_nxt_s;
    logic             issue_ok_nxt_s;
    logic             out_valid_nxt_s;
    logic [WIDTH-1:0] out_data_nxt_s;
    logic [CW:0]      credit_sum_s;

    // Event decode and next-state computation for counters, pointers and outputs.
    always_comb begin
        acc_issue_s    = issue & issue_ok_r;
        // A word is only accepted if a credit was actually outstanding and a
        // slot is free; anything else is a protocol violation and is dropped.
        push_s         = in_valid & (inflight_r != {CW{1'b0}}) & (count_r != DEPTH_C);
        pop_s          = out_valid_r & out_ready;

        inflight_nxt_s = inflight_r;
        count_nxt_s    = count_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        err_nxt_s      = err_r;
        out_data_nxt_s = {WIDTH{1'b0}};

        case ({acc_issue_s, push_s})
            2'b10:   inflight_nxt_s = inflight_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   inflight_nxt_s = inflight_r - {{(CW-1){1'b0}}, 1'b1};
            default: inflight_nxt_s = inflight_r;
        endcase

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase

        if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if ((issue && !issue_ok_r) || (in_valid && !push_s)) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end

        // Registered head: when the new head is the slot being written on
        // this same edge (push into empty, or push+pop at count 1), forward
        // in_data because mem_r does not hold it yet.
        if (count_nxt_s == {CW{1'b0}}) begin
            out_data_nxt_s = {WIDTH{1'b0}};
        end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            out_data_nxt_s = in_data;
        end else begin
            out_data_nxt_s = mem_r[rd_ptr_nxt_s];
        end

        out_valid_nxt_s = (count_nxt_s != {CW{1'b0}});
        credit_sum_s    = {1'b0, inflight_nxt_s} + {1'b0, count_nxt_s};
        issue_ok_nxt_s  = (credit_sum_s < {1'b0, DEPTH_C});
    end

    // Storage array; contents need no reset since count/pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r  <= {CW{1'b0}};
            count_r     <= {CW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            err_r       <= 1'b0;
            issue_ok_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else begin
            inflight_r  <= inflight_nxt_s;
            count_r     <= count_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            err_r       <= err_nxt_s;
            issue_ok_r  <= issue_ok_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    assign issue_ok  = issue_ok_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign count     = count_r;
    assign err       = err_r;

endmodule

// File: tb/tb_delay_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_delay_rx_buffer
//
// Self-checking bench for delay_rx_buffer. Instance "dut" uses DEPTH=8,
// instance "dut5" uses DEPTH=5. Expected values come from a directed vector
// table and from a queue-based reference model of the credit/FIFO rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_delay_rx_buffer;

    localparam int W   = 32;
    localparam int L   = 4;
    localparam int D   = 8;
    localparam int CW  = $clog2(D + 1);
    localparam int D5  = 5;
    localparam int CW5 = $clog2(D5 + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          issue, issue_ok, in_valid, out_valid, out_ready, err;
    logic [W-1:0]  in_data, out_data;
    logic [CW-1:0] count;

    logic           b_issue, b_issue_ok, b_in_valid, b_out_valid, b_out_ready, b_err;
    logic [W-1:0]   b_in_data, b_out_data;
    logic [CW5-1:0] b_count;

    always #5 clk = ~clk;

    delay_rx_buffer #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .count(count), .err(err)
    );

    delay_rx_buffer #(.WIDTH(W), .LATENCY(L), .DEPTH(D5)) dut5 (
        .clk(clk), .rst(rst), .issue(b_issue), .issue_ok(b_issue_ok),
        .in_valid(b_in_valid), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .count(b_count), .err(b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (DEPTH=8 instance) ----------------
    logic [W-1:0] mq[$];
    int           m_infl;
    bit           m_err;
    logic [W-1:0] rx[$];

    function automatic bit m_ok();
        return (m_infl + mq.size()) < D;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_infl = 0;
        m_err  = 1'b0;
    endtask

    task automatic m_step(input bit iss, input bit iv, input logic [W-1:0] d, input bit rdy);
        bit acc, do_pop, do_push;
        acc     = iss && m_ok();
        do_pop  = (mq.size() > 0) && rdy;
        do_push = iv && (m_infl > 0) && (mq.size() < D);
        if (iss && !acc) m_err = 1'b1;
        if (iv && !do_push) m_err = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
        m_infl = m_infl + int'(acc) - int'(do_push);
    endtask

    task automatic m_check(input string tag);
        chk({tag, " count"}, 32'(count), 32'(mq.size()));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, " out_data"}, out_data, (mq.size() != 0) ? mq[0] : 32'h0);
        chk({tag, " issue_ok"}, 32'(issue_ok), 32'(m_ok()));
        chk({tag, " err"}, 32'(err), 32'(m_err));
    endtask

    // One clock cycle on the DEPTH=8 instance, checked against the model.
    task automatic drive(input bit iss, input bit iv, input logic [W-1:0] d, input bit rdy,
                         input string tag, output bit acc);
        issue = iss; in_valid = iv; in_data = d; out_ready = rdy;
        acc = iss && m_ok();
        if (out_valid && rdy) rx.push_back(out_data);
        @(posedge clk);
        m_step(iss, iv, d, rdy);
        #1;
        m_check(tag);
    endtask

    // ---------------- LATENCY-cycle delay line model ----------------
    bit           sh_v[L];
    logic [W-1:0] sh_d[L];
    int           next_data;

    task automatic clear_pipe();
        for (int i = 0; i < L; i++) begin
            sh_v[i] = 1'b0;
            sh_d[i] = '0;
        end
    endtask

    task automatic stream_step(input bit iss_req, input bit rdy, input logic [W-1:0] d,
                               input string tag, output bit acc);
        drive(iss_req, sh_v[L-1], sh_v[L-1] ? sh_d[L-1] : 32'h0, rdy, tag, acc);
        for (int i = L - 1; i > 0; i--) begin
            sh_v[i] = sh_v[i-1];
            sh_d[i] = sh_d[i-1];
        end
        sh_v[0] = acc;
        sh_d[0] = d;
        if (acc) next_data++;
    endtask

    task automatic do_reset();
        issue = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_issue = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        m_reset();
        clear_pipe();
        rx.delete();
        next_data = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          iss;
        bit          iv;
        logic [31:0] d;
        bit          rdy;
        int          e_cnt;
        bit          e_ov;
        logic [31:0] e_od;
        bit          e_ok;
        bit          e_err;
    } vec_t;

    vec_t tv[12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit acc;
        int accepted;
        int maxc;
        int b_next;
        bit           bsh_v[L];
        logic [W-1:0] bsh_d[L];
        logic [W-1:0] rxb[$];

        // iss iv data rdy | cnt ov od ok err
        tv[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1'b1, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1'b1, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 32'hA000_0001, 1'b0, 1, 1'b1, 32'hA000_0001, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 32'hA000_0002, 1'b0, 2, 1'b1, 32'hA000_0001, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1, 1'b1, 32'hA000_0002, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 32'hA000_0003, 1'b1, 1, 1'b1, 32'hA000_0003, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1, 1'b1, 32'hA000_0003, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 32'hA000_0004, 1'b1, 1, 1'b1, 32'hA000_0004, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 32'h0000_0055, 1'b0, 1, 1'b1, 32'hA000_0004, 1'b1, 1'b1};
        tv[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b1, 1'b1};
        tv[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b1, 1'b1};

        do_reset();
        chk("reset count", 32'(count), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset issue_ok", 32'(issue_ok), 32'd1);
        chk("reset err", 32'(err), 32'd0);

        // Table: empty->push latency, push+pop at count 1, in_valid without credit.
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].iss, tv[i].iv, tv[i].d, tv[i].rdy, "tbl_model", acc);
            chk($sformatf("tbl[%0d] count", i), 32'(count), 32'(tv[i].e_cnt));
            chk($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
            chk($sformatf("tbl[%0d] out_data", i), out_data, tv[i].e_od);
            chk($sformatf("tbl[%0d] issue_ok", i), 32'(issue_ok), 32'(tv[i].e_ok));
            chk($sformatf("tbl[%0d] err", i), 32'(err), 32'(tv[i].e_err));
        end

        // Streaming: issue every cycle, consumer always ready, 0..99 in order.
        do_reset();
        for (int c = 0; c < 120; c++) begin
            stream_step(next_data < 100, 1'b1, 32'(next_data), "stream", acc);
            chk("stream issue_ok high", 32'(issue_ok), 32'd1);
        end
        chk("stream rx size", 32'(rx.size()), 32'd100);
        for (int i = 0; i < rx.size(); i++) chk($sformatf("stream rx[%0d]", i), rx[i], 32'(i));

        // Backpressure: fill credits, illegal issue, then drain.
        do_reset();
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            stream_step(m_ok(), 1'b0, 32'(next_data), "bp_fill", acc);
            if (acc) accepted++;
        end
        chk("bp accepted", 32'(accepted), 32'd8);
        chk("bp count full", 32'(count), 32'd8);
        chk("bp issue_ok low", 32'(issue_ok), 32'd0);
        stream_step(1'b1, 1'b0, 32'(next_data), "bp_viol", acc);
        chk("viol err set", 32'(err), 32'd1);
        chk("viol count held", 32'(count), 32'd8);
        chk("viol issue_ok low", 32'(issue_ok), 32'd0);
        stream_step(1'b0, 1'b1, 32'(next_data), "bp_pop1", acc);
        chk("bp issue_ok after first pop", 32'(issue_ok), 32'd1);
        chk("bp count after first pop", 32'(count), 32'd7);
        for (int c = 0; c < 12; c++) stream_step(1'b0, 1'b1, 32'(next_data), "bp_drain", acc);
        chk("bp rx size", 32'(rx.size()), 32'd8);
        for (int i = 0; i < rx.size(); i++) chk($sformatf("bp rx[%0d]", i), rx[i], 32'(i));
        chk("err sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-stream with count=3 and words still in flight.
        do_reset();
        for (int c = 0; c < 7; c++) stream_step(1'b1, 1'b0, 32'(next_data), "pre_rst", acc);
        chk("pre_rst count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst issue_ok", 32'(issue_ok), 32'd1);
        chk("async rst err", 32'(err), 32'd0);
        chk("async rst out_data", out_data, 32'd0);
        m_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        // Words launched before reset still arrive and must flag err.
        for (int c = 0; c < 6; c++) stream_step(1'b0, 1'b1, 32'(next_data), "post_rst", acc);
        chk("forgotten words err", 32'(err), 32'd1);
        chk("forgotten words count", 32'(count), 32'd0);

        // Randomized traffic against the model; rare illegal issues late on.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int r;
            bit rdy;
            r   = int'($urandom_range(0, 99));
            rdy = ($urandom_range(0, 99) < 55);
            stream_step((r < 60) && (m_ok() || (c > 200 && r < 3)), rdy, $urandom, "rand", acc);
        end

        // DEPTH=5 instance: 12 words through repeated full/empty phases.
        do_reset();
        b_next = 0;
        maxc   = 0;
        for (int i = 0; i < L; i++) begin
            bsh_v[i] = 1'b0;
            bsh_d[i] = '0;
        end
        for (int c = 0; c < 300 && rxb.size() < 12; c++) begin
            b_out_ready = ((c / 10) % 2) == 1;
            b_in_valid  = bsh_v[L-1];
            b_in_data   = bsh_v[L-1] ? bsh_d[L-1] : 32'h0;
            b_issue     = (b_next < 12) && b_issue_ok;
            acc         = b_issue;
            if (b_out_valid && b_out_ready) rxb.push_back(b_out_data);
            @(posedge clk);
            #1;
            for (int i = L - 1; i > 0; i--) begin
                bsh_v[i] = bsh_v[i-1];
                bsh_d[i] = bsh_d[i-1];
            end
            bsh_v[0] = acc;
            bsh_d[0] = 32'(b_next);
            if (acc) b_next++;
            if (int'(b_count) > maxc) maxc = int'(b_count);
        end
        b_issue = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        chk("d5 max count", 32'(maxc), 32'd5);
        chk("d5 rx size", 32'(rxb.size()), 32'd12);
        for (int i = 0; i < rxb.size(); i++) chk($sformatf("d5 rx[%0d]", i), rxb[i], 32'(i));
        chk("d5 err", 32'(b_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
